// File: rtl/hsk_pulse_pkg.sv
// Shared types and constants for the handshake pulse feeder and its saturating counter.
package hsk_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } feeder_state_e;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/hsk_sat_counter.sv
// Up/down saturating counter with synchronous clear and a same-cycle overflow strobe.
module hsk_sat_counter #(
    parameter int W      = 8,
    parameter bit OVF_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_VAL  = {W{1'b1}};
    localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
    localparam logic [W-1:0] ONE_VAL  = W'(1'b1);

    logic [W-1:0] count_r;

    // Count register: increment saturates at MAX_VAL, decrement refuses to wrap below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO_VAL;
        end else if (clr) begin
            count_r <= ZERO_VAL;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (count_r != MAX_VAL) begin
                        count_r <= count_r + ONE_VAL;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    if (count_r != ZERO_VAL) begin
                        count_r <= count_r - ONE_VAL;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    // Strobe marks the cycle in which an increment is discarded; clear suppresses it.
    assign ovf   = OVF_EN & ~clr & inc & ~dec & (count_r == MAX_VAL);

endmodule

// File: rtl/hsk_pulse_feeder.sv
// Source-domain feeder: queues event pulses and replays them as tvalid_o handshakes.
// Optional sticky overflow flag enabled by macro HSK_PULSE_FEEDER_OVERFLOW_EN.
module hsk_pulse_feeder
    import hsk_pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             aclk_i,
    input  logic             arstn_i,
    input  logic             clear_i,
    input  logic             event_i,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic [CNT_W-1:0] pending_o,
    output logic             overflow_o
);

`ifdef HSK_PULSE_FEEDER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    feeder_state_e    state_r;
    feeder_state_e    state_s;
    logic             tvalid_r;
    logic             xfer_s;
    logic             ovf_stb_s;
    logic [CNT_W-1:0] pend_s;

    assign xfer_s = tvalid_r & tready_i;

    hsk_sat_counter #(
        .W      (CNT_W),
        .OVF_EN (OVF_EN)
    ) u_cnt (
        .clk   (aclk_i),
        .rst_n (arstn_i),
        .clr   (clear_i),
        .inc   (event_i),
        .dec   (xfer_s),
        .count (pend_s),
        .ovf   (ovf_stb_s)
    );

    // Next-state decode; HOLD deliberately ignores tready_i for one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if ((pend_s != {CNT_W{1'b0}}) && tready_i) begin
                    state_s = FIRE;
                end else begin
                    state_s = IDLE;
                end
            end
            FIRE: begin
                if (tready_i) begin
                    state_s = HOLD;
                end else begin
                    state_s = FIRE;
                end
            end
            HOLD: state_s = WAIT;
            WAIT: begin
                if (tready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with tvalid registered from the upcoming FIRE state.
    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r  <= IDLE;
            tvalid_r <= 1'b0;
        end else if (clear_i) begin
            state_r  <= IDLE;
            tvalid_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            tvalid_r <= (state_s == FIRE);
        end
    end

`ifdef HSK_PULSE_FEEDER_OVERFLOW_EN
    logic overflow_r;

    // Sticky record of any dropped event, cleared only by reset or clear_i.
    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            overflow_r <= 1'b0;
        end else if (clear_i) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r | ovf_stb_s;
        end
    end

    assign overflow_o = overflow_r;
`else
    // Counter is built without its strobe here, so this is a constant 0.
    assign overflow_o = ovf_stb_s;
`endif

    assign tvalid_o  = tvalid_r;
    assign pending_o = pend_s;

endmodule

// File: tb/tb_hsk_pulse_feeder.sv
// Randomized and directed bench for hsk_pulse_feeder at CNT_W=8 and CNT_W=2 against a rule-level model.
module tb_hsk_pulse_feeder;

    logic       aclk_i   = 1'b0;
    logic       arstn_i  = 1'b0;
    logic       clear_i  = 1'b0;
    logic       event_i  = 1'b0;
    logic       tready_i = 1'b0;
    logic       tvalid8, tvalid2, ovf8, ovf2;
    logic [7:0] pend8;
    logic [1:0] pend2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int pend;
        bit ovf;
        bit req;      // request outstanding toward the synchronizer
        bit blind;    // the one cycle right after a transfer
        bit waiting;  // waiting for the synchronizer to come back ready
    } mdl_t;

    mdl_t m8, m2;

    always #5 aclk_i = ~aclk_i;

    hsk_pulse_feeder #(.CNT_W(8)) dut8 (
        .aclk_i(aclk_i), .arstn_i(arstn_i), .clear_i(clear_i), .event_i(event_i),
        .tvalid_o(tvalid8), .tready_i(tready_i), .pending_o(pend8), .overflow_o(ovf8)
    );

    hsk_pulse_feeder #(.CNT_W(2)) dut2 (
        .aclk_i(aclk_i), .arstn_i(arstn_i), .clear_i(clear_i), .event_i(event_i),
        .tvalid_o(tvalid2), .tready_i(tready_i), .pending_o(pend2), .overflow_o(ovf2)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mdl_t step(mdl_t m, bit rst, bit ev, bit rdy, bit clr, int maxv);
        mdl_t n;
        bit   xfer;
        n = m;
        if (rst || clr) begin
            n = '{default: 0};
            return n;
        end
        xfer = m.req && rdy;
        if (ev && !xfer) begin
            if (m.pend == maxv) n.ovf = 1'b1;
            else                n.pend = m.pend + 1;
        end else if (!ev && xfer) begin
            n.pend = m.pend - 1;
        end
        if (m.req) begin
            if (rdy) begin
                n.req   = 1'b0;
                n.blind = 1'b1;
            end
        end else if (m.blind) begin
            n.blind   = 1'b0;
            n.waiting = 1'b1;
        end else if (m.waiting) begin
            if (rdy) n.waiting = 1'b0;
        end else if (m.pend != 0 && rdy) begin
            n.req = 1'b1;
        end
        return n;
    endfunction

    function automatic bit ovf_exp(mdl_t m);
`ifdef HSK_PULSE_FEEDER_OVERFLOW_EN
        return m.ovf;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_all();
        check_value("tvalid_w8",   {31'd0, tvalid8}, {31'd0, m8.req});
        check_value("pending_w8",  {24'd0, pend8},   m8.pend);
        check_value("overflow_w8", {31'd0, ovf8},    {31'd0, ovf_exp(m8)});
        check_value("tvalid_w2",   {31'd0, tvalid2}, {31'd0, m2.req});
        check_value("pending_w2",  {30'd0, pend2},   m2.pend);
        check_value("overflow_w2", {31'd0, ovf2},    {31'd0, ovf_exp(m2)});
    endtask

    // Drive one cycle of inputs from a falling edge, advance models, check at the next falling edge.
    task automatic cyc(input bit ev, input bit rdy, input bit clr);
        event_i  = ev;
        tready_i = rdy;
        clear_i  = clr;
        m8 = step(m8, !arstn_i, ev, rdy, clr, 255);
        m2 = step(m2, !arstn_i, ev, rdy, clr, 3);
        @(negedge aclk_i);
        compare_all();
    endtask

    initial begin
        int  xfers;
        int  peak;
        int  cool;
        bit  rdy;
        bit  mx;
        m8 = '{default: 0};
        m2 = '{default: 0};
        @(negedge aclk_i);

        // reset held for 100 ns while events toggle
        for (int i = 0; i < 10; i++) cyc(i % 2 == 0, 1'b1, 1'b0);
        arstn_i = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);

        // single event with tready high
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        check_value("single_pend1", {24'd0, pend8}, 32'd1);
        check_value("single_nov",   {31'd0, tvalid8}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check_value("single_valid", {31'd0, tvalid8}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        check_value("single_drop",  {31'd0, tvalid8}, 32'd0);
        check_value("single_pend0", {24'd0, pend8}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0);

        // burst of 5, synchronizer busy for 10 cycles after every transfer
        cyc(1'b0, 1'b0, 1'b1);
        xfers = 0; peak = 0; cool = 0;
        for (int i = 0; i < 150; i++) begin
            rdy = (cool == 0) && (i >= 5);
            if (tvalid8 && rdy) xfers++;
            mx = m8.req && rdy;
            cyc(i < 5, rdy, 1'b0);
            if (pend8 > peak) peak = pend8;
            if (mx) cool = 10;
            else if (cool > 0) cool--;
        end
        check_value("burst_xfers", xfers, 32'd5);
        check_value("burst_peak",  peak,  32'd5);
        check_value("burst_end",   {24'd0, pend8}, 32'd0);

        // event coincides with a transfer at pending 3
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        check_value("coinc_pre", {24'd0, pend8}, 32'd3);
        cyc(1'b0, 1'b1, 1'b0);
        check_value("coinc_fire", {31'd0, tvalid8}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        check_value("coinc_hold", {24'd0, pend8}, 32'd3);

        // saturation on the 2-bit instance
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0);
        check_value("sat_pend2", {30'd0, pend2}, 32'd3);
        check_value("sat_pend8", {24'd0, pend8}, 32'd5);
`ifdef HSK_PULSE_FEEDER_OVERFLOW_EN
        check_value("sat_ovf2", {31'd0, ovf2}, 32'd1);
`else
        check_value("sat_ovf2", {31'd0, ovf2}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b1);
        check_value("clr_pend2", {30'd0, pend2}, 32'd0);
        check_value("clr_ovf2",  {31'd0, ovf2},  32'd0);

        // tready withdrawn while the request is up
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check_value("fire_held", {31'd0, tvalid8}, 32'd1);
        end
        check_value("fire_pend", {24'd0, pend8}, 32'd2);
        cyc(1'b0, 1'b1, 1'b0);
        check_value("fire_dec",  {24'd0, pend8}, 32'd1);
        check_value("fire_done", {31'd0, tvalid8}, 32'd0);

        // asynchronous reset while the request is up
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check_value("arst_pre", {31'd0, tvalid8}, 32'd1);
        #2 arstn_i = 1'b0;
        #1;
        check_value("arst_valid", {31'd0, tvalid8}, 32'd0);
        check_value("arst_pend",  {24'd0, pend8},   32'd0);
        m8 = '{default: 0};
        m2 = '{default: 0};
        @(negedge aclk_i);
        cyc(1'b1, 1'b1, 1'b0);
        arstn_i = 1'b1;

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
